instr_fetch: RTL and testbench

//   Instruction fetch stage directly upstream of immediate extension/decode.

---
 rtl/instr_fetch_if.sv | 26 ++
 rtl/instr_fetch.sv | 116 +++++++++++
 tb/tb_instr_fetch.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read handshake plus the
// valid/ready instruction hand-off to decode.
interface instr_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        instr_valid;
   logic        instr_ready;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      output instr_out, pc_out, instr_valid,
      input  instr_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      input  instr_out, pc_out, instr_valid,
      output instr_ready
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, single-outstanding imem read, instruction register
// with valid/ready to decode, redirect handling and sticky error flags.
module instr_fetch #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          redirect,
   input  logic [31:0]   redirect_pc,
   instr_fetch_if.master bus,
   output logic          misalign_err,
   output logic          timeout_err
);

   localparam int unsigned CW = ($clog2(ACK_TIMEOUT + 1) < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
   localparam logic [CW-1:0] LIM = CW'(ACK_TIMEOUT);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

   state_t        state, state_d;
   logic [31:0]   pc, pc_d;
   logic [31:0]   addr, addr_d;
   logic [31:0]   instr_q, pc_out_q;
   logic [CW-1:0] wait_cnt, wait_cnt_d;
   logic          capture, start;
   logic          redir, misaligned, waiting;

   assign redir      = redirect && (redirect_pc[1:0] == 2'b00);
   assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);
   assign waiting    = ((state == REQ) || (state == DRAIN)) && !bus.imem_ack;

   // A redirect only retargets pc; the request address is latched separately
   // so an in-flight (draining) request keeps its original address.
   always_comb begin
      state_d = state;
      pc_d    = pc;
      addr_d  = addr;
      capture = 1'b0;
      start   = 1'b0;
      if (redir) pc_d = redirect_pc;
      unique case (state)
         IDLE: begin
            if (en) begin
               state_d = REQ;
               start   = 1'b1;
            end
         end
         REQ: begin
            if (redir) begin
               if (bus.imem_ack) begin
                  state_d = en ? REQ : IDLE;
                  start   = en;
               end else begin
                  state_d = DRAIN;
               end
            end else if (bus.imem_ack) begin
               capture = 1'b1;
               pc_d    = pc + 32'd4;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (redir || bus.instr_ready) begin
               state_d = en ? REQ : IDLE;
               start   = en;
            end
         end
         DRAIN: begin
            if (bus.imem_ack) begin
               state_d = en ? REQ : IDLE;
               start   = en;
            end
         end
         default: state_d = IDLE;
      endcase
      if (start) addr_d = pc_d;
   end

   always_comb begin
      wait_cnt_d = '0;
      if (waiting) wait_cnt_d = (wait_cnt == LIM) ? wait_cnt : wait_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         pc           <= RESET_PC;
         addr         <= RESET_PC;
         instr_q      <= '0;
         pc_out_q     <= '0;
         wait_cnt     <= '0;
         misalign_err <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         state    <= state_d;
         pc       <= pc_d;
         addr     <= addr_d;
         wait_cnt <= wait_cnt_d;
         if (capture) begin
            instr_q  <= bus.imem_rdata;
            pc_out_q <= pc;
         end
         if (misaligned) misalign_err <= 1'b1;
         if (waiting && (wait_cnt_d == LIM)) timeout_err <= 1'b1;
      end
   end

   assign bus.imem_req    = (state == REQ) || (state == DRAIN);
   assign bus.imem_addr   = addr;
   assign bus.instr_out   = instr_q;
   assign bus.pc_out      = pc_out_q;
   assign bus.instr_valid = (state == HOLD);

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected fetch addresses and delivered
// instructions are queued by the stimulus and popped by negedge monitors.
module tb_instr_fetch;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        misalign_err, timeout_err;

   instr_fetch_if bus ();

   instr_fetch #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(255)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .redirect(redirect),
      .redirect_pc(redirect_pc), .bus(bus),
      .misalign_err(misalign_err), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] addr_q[$];
   logic [63:0] instr_q[$];
   bit resp_on = 1'b1, hold_ack = 1'b0, fixed = 1'b1, lat_chk = 1'b0;
   int ack_delay = 1;
   logic prev_ack = 1'b0, prev_hs = 1'b0;
   logic [63:0] exp_e;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return fixed ? 32'h2001_0005 : (32'hC0DE_0000 ^ a);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input int bound);
      int n;
      n = 0;
      while (n < bound) begin
         if (addr_q.size() == 0) en = 1'b0;
         if (addr_q.size() == 0 && instr_q.size() == 0 && !bus.imem_req && !bus.instr_valid) break;
         tick();
         n++;
      end
      check1("drain_in_time", (n < bound), 1'b1);
   endtask

   task automatic wait_req(input int bound);
      int n;
      n = 0;
      while (!bus.imem_req && n < bound) begin
         tick();
         n++;
      end
      check1("req_seen", bus.imem_req, 1'b1);
   endtask

   task automatic wait_valid(input int bound);
      int n;
      n = 0;
      while (!bus.instr_valid && n < bound) begin
         tick();
         n++;
      end
      check1("valid_seen", bus.instr_valid, 1'b1);
   endtask

   task automatic pulse_redirect(input logic [31:0] target);
      redirect    = 1'b1;
      redirect_pc = target;
      tick();
      redirect    = 1'b0;
   endtask

   // Memory model: acks ack_delay cycles after req is first seen, one cycle wide.
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!resp_on) cnt = 0;
         else if (!rst_n) begin
            bus.imem_ack = 1'b0;
            cnt = 0;
         end else if (bus.imem_ack) bus.imem_ack = 1'b0;
         else if (bus.imem_req && !hold_ack) begin
            if (cnt >= ack_delay) begin
               bus.imem_ack   = 1'b1;
               bus.imem_rdata = mem(bus.imem_addr);
               cnt = 0;
            end else cnt++;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.imem_ack && bus.imem_req) begin
            if (addr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_fetch: got addr %h expected none", bus.imem_addr);
            end else check("imem_addr", bus.imem_addr, addr_q.pop_front());
         end
         if (bus.instr_valid && bus.instr_ready) begin
            if (instr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_instr: got %h@%h expected none", bus.instr_out, bus.pc_out);
            end else begin
               exp_e = instr_q.pop_front();
               check("instr_out", bus.instr_out, exp_e[63:32]);
               check("pc_out", bus.pc_out, exp_e[31:0]);
            end
         end
         if (lat_chk) begin
            if (prev_ack) check1("valid_after_ack", bus.instr_valid, 1'b1);
            if (prev_hs) check1("req_after_ready", bus.imem_req, 1'b1);
         end
      end
      prev_ack = bus.imem_ack && bus.imem_req;
      prev_hs  = bus.instr_valid && bus.instr_ready && en;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.imem_ack    = 1'b0;
      bus.imem_rdata  = '0;
      bus.instr_ready = 1'b0;
      #12;
      check1("rst_req", bus.imem_req, 1'b0);
      check("rst_addr", bus.imem_addr, 32'h0);
      check("rst_instr", bus.instr_out, 32'h0);
      check("rst_pc_out", bus.pc_out, 32'h0);
      check1("rst_valid", bus.instr_valid, 1'b0);
      check1("rst_misalign", misalign_err, 1'b0);
      check1("rst_timeout", timeout_err, 1'b0);
      tick();
      rst_n = 1'b1;

      // Sequential fetch 0,4,8 with a constant word.
      lat_chk = 1'b1;
      bus.instr_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         addr_q.push_back(32'(i * 4));
         instr_q.push_back({32'h2001_0005, 32'(i * 4)});
      end
      en = 1'b1;
      drain(100);

      // Decode stall in HOLD.
      fixed = 1'b0;
      bus.instr_ready = 1'b0;
      addr_q.push_back(32'hC);
      instr_q.push_back({mem(32'hC), 32'hC});
      en = 1'b1;
      wait_valid(50);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check1("stall_valid", bus.instr_valid, 1'b1);
         check("stall_instr", bus.instr_out, 32'hC0DE_000C);
         check("stall_pc", bus.pc_out, 32'hC);
         check1("stall_no_req", bus.imem_req, 1'b0);
      end
      tick();
      addr_q.push_back(32'h10);
      instr_q.push_back({mem(32'h10), 32'h10});
      bus.instr_ready = 1'b1;
      tick();
      @(negedge clk);
      check1("req_after_stall", bus.imem_req, 1'b1);
      check("addr_after_stall", bus.imem_addr, 32'h10);
      drain(100);
      lat_chk = 1'b0;

      // Redirect while a request at 0x8 is waiting for its ack.
      pulse_redirect(32'h8);
      hold_ack = 1'b1;
      addr_q.push_back(32'h8);
      addr_q.push_back(32'h100);
      instr_q.push_back({mem(32'h100), 32'h100});
      en = 1'b1;
      wait_req(10);
      pulse_redirect(32'h100);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check1("drain_req", bus.imem_req, 1'b1);
         check("drain_addr", bus.imem_addr, 32'h8);
         check1("drain_no_valid", bus.instr_valid, 1'b0);
      end
      tick();
      ack_delay = 0;
      hold_ack  = 1'b0;
      drain(100);
      ack_delay = 1;

      // Misaligned redirect is ignored apart from the sticky flag.
      pulse_redirect(32'h102);
      @(negedge clk);
      check1("misalign_set", misalign_err, 1'b1);
      tick();
      addr_q.push_back(32'h104);
      instr_q.push_back({mem(32'h104), 32'h104});
      en = 1'b1;
      drain(100);
      check1("misalign_sticky", misalign_err, 1'b1);

      // PC wraps from the top word to zero.
      pulse_redirect(32'hFFFF_FFFC);
      addr_q.push_back(32'hFFFF_FFFC);
      addr_q.push_back(32'h0);
      instr_q.push_back({mem(32'hFFFF_FFFC), 32'hFFFF_FFFC});
      instr_q.push_back({mem(32'h0), 32'h0});
      en = 1'b1;
      drain(100);

      // Ack timeout, then asynchronous reset mid-wait.
      hold_ack = 1'b1;
      en = 1'b1;
      wait_req(10);
      en = 1'b0;
      @(negedge clk);
      repeat (254) @(negedge clk);
      check1("timeout_not_yet", timeout_err, 1'b0);
      @(negedge clk);
      check1("timeout_set", timeout_err, 1'b1);
      check1("timeout_req_held", bus.imem_req, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      check1("arst_req", bus.imem_req, 1'b0);
      check1("arst_timeout", timeout_err, 1'b0);
      check1("arst_misalign", misalign_err, 1'b0);
      check1("arst_valid", bus.instr_valid, 1'b0);
      check("arst_addr", bus.imem_addr, 32'h0);
      resp_on  = 1'b0;
      hold_ack = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.imem_ack = 1'b1;
      tick();
      bus.imem_ack = 1'b0;
      tick(3);
      @(negedge clk);
      check1("late_ack_no_req", bus.imem_req, 1'b0);
      check1("late_ack_no_valid", bus.instr_valid, 1'b0);
      check("late_ack_instr", bus.instr_out, 32'h0);
      check("addr_q_empty", 32'(addr_q.size()), 32'h0);
      check("instr_q_empty", 32'(instr_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
